// File: rtl/pc_stack_unit_pkg.sv
// pc_pkg: shared operation encoding and default sizes for the program-counter
// unit and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    OP_NEXT = 2'b00,
    OP_GOTO = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } pc_op_e;

  localparam int PC_W_DEF      = 13;
  localparam int STK_DEPTH_DEF = 8;

endpackage

// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if: sequencing request (en/op/skip/target) from the decoder
// and the fetch address plus stack status returned by the PC unit.
interface pc_stack_unit_if #(
  parameter int PC_W  = pc_pkg::PC_W_DEF,
  parameter int DEPTH = pc_pkg::STK_DEPTH_DEF
);
  import pc_pkg::*;

  logic                       en;
  pc_op_e                     op;
  logic                       skip;
  logic [PC_W-1:0]            target;
  logic [PC_W-1:0]            counter;
  logic [$clog2(DEPTH+1)-1:0] sp;
  logic                       full;
  logic                       empty;
  logic                       stk_err;

  modport master (
    output en, op, skip, target,
    input  counter, sp, full, empty, stk_err
  );

  modport slave (
    input  en, op, skip, target,
    output counter, sp, full, empty, stk_err
  );

endinterface

// File: rtl/pc_stack_unit_stack.sv
// pc_stack: circular return-address LIFO with saturating occupancy count.
// Build option PC_STACK_OVF_TRAP_EN: CALL while full / RET while empty are
// suppressed and raise a sticky error; otherwise the buffer simply wraps.
module pc_stack
  import pc_pkg::*;
#(
  parameter int  PC_W  = PC_W_DEF,
  parameter int  DEPTH = STK_DEPTH_DEF,
  localparam int WP_W  = $clog2(DEPTH),
  localparam int SP_W  = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            fault,
  output logic            err
);

  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [WP_W-1:0] wp;
  logic [WP_W-1:0] wp_dec;
  logic [SP_W-1:0] cnt;
  logic            do_push;
  logic            do_pop;

  assign sp       = cnt;
  assign full     = (cnt == SP_MAX);
  assign empty    = (cnt == '0);
  assign wp_dec   = wp - WP_W'(1);
  assign pop_data = mem[wp_dec];

`ifdef PC_STACK_OVF_TRAP_EN
  assign fault = (push && full) || (pop && empty);
`else
  assign fault = 1'b0;
`endif

  assign do_push = en && push && !fault;
  assign do_pop  = en && pop && !fault;

  // Storage, pointer and saturating count; push and pop never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wp] <= push_data;
      wp      <= wp + WP_W'(1);
      if (!full) cnt <= cnt + SP_W'(1);
    end else if (do_pop) begin
      wp <= wp_dec;
      if (!empty) cnt <= cnt - SP_W'(1);
    end
  end

`ifdef PC_STACK_OVF_TRAP_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            err <= 1'b0;
    else if (en && fault) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment/skip/jump/call/return
// sequencing backed by a hardware return-address stack (pc_stack).
// Build option PC_STACK_OVF_TRAP_EN enables stack fault trapping.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int DEPTH   = STK_DEPTH_DEF,
  parameter int RST_VEC = 0
) (
  input  logic              clk,
  input  logic              reset,
  pc_stack_unit_if.slave    bus
);

  localparam int SP_W = $clog2(DEPTH+1);

  logic [PC_W-1:0] counter;
  logic [PC_W-1:0] counter_nxt;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] pop_data;
  logic [SP_W-1:0] sp;
  logic            full;
  logic            empty;
  logic            fault;
  logic            err;

  assign ret_addr = counter + PC_W'(1);

  pc_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .push      (bus.op == OP_CALL),
    .pop       (bus.op == OP_RET),
    .push_data (ret_addr),
    .pop_data  (pop_data),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .fault     (fault),
    .err       (err)
  );

  // Next-PC selection; a trapped stack fault leaves the counter in place.
  always_comb begin
    counter_nxt = counter;
    case (bus.op)
      OP_NEXT: counter_nxt = counter + (bus.skip ? PC_W'(2) : PC_W'(1));
      OP_GOTO: counter_nxt = bus.target;
      OP_CALL: counter_nxt = fault ? counter : bus.target;
      OP_RET:  counter_nxt = fault ? counter : pop_data;
      default: counter_nxt = counter;
    endcase
  end

  // Fetch-address register, advanced only when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       counter <= PC_W'(RST_VEC);
    else if (bus.en) counter <= counter_nxt;
  end

  assign bus.counter = counter;
  assign bus.sp      = sp;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.stk_err = err;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed scenarios plus randomized op streams, every
// cycle compared against a behavioural model of the PC and return stack.
module tb_pc_stack_unit;
  import pc_pkg::*;

  localparam int PC_W  = 13;
  localparam int DEPTH = 8;
  localparam int MOD   = 1 << PC_W;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  // model state
  int m_pc;
  int m_mem [DEPTH];
  int m_wp;
  int m_sp;
  bit m_err;

  pc_stack_unit_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .RST_VEC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_wp = 0; m_sp = 0; m_err = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
  endfunction

  function automatic void model_op(input bit e, input pc_op_e o, input bit s, input int t);
    bit trap = 0;
`ifdef PC_STACK_OVF_TRAP_EN
    trap = 1;
`endif
    if (!e) return;
    case (o)
      OP_NEXT: m_pc = (m_pc + 1 + int'(s)) % MOD;
      OP_GOTO: m_pc = t % MOD;
      OP_CALL: begin
        if (trap && m_sp == DEPTH) m_err = 1;
        else begin
          m_mem[m_wp] = (m_pc + 1) % MOD;
          m_wp = (m_wp + 1) % DEPTH;
          m_sp = (m_sp < DEPTH) ? m_sp + 1 : DEPTH;
          m_pc = t % MOD;
        end
      end
      OP_RET: begin
        if (trap && m_sp == 0) m_err = 1;
        else begin
          m_wp = (m_wp + DEPTH - 1) % DEPTH;
          m_pc = m_mem[m_wp];
          m_sp = (m_sp > 0) ? m_sp - 1 : 0;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, "_pc"},    32'(bus.counter), 32'(m_pc));
    chk({tag, "_sp"},    32'(bus.sp),      32'(m_sp));
    chk({tag, "_full"},  32'(bus.full),    32'(m_sp == DEPTH));
    chk({tag, "_empty"}, 32'(bus.empty),   32'(m_sp == 0));
    chk({tag, "_err"},   32'(bus.stk_err), 32'(m_err));
  endtask

  task automatic step(input string tag, input bit e, input pc_op_e o, input bit s, input int t);
    logic [31:0] tv;
    tv = t;
    bus.en = e; bus.op = o; bus.skip = s; bus.target = tv[PC_W-1:0];
    @(posedge clk);
    model_op(e, o, s, t);
    #1;
    compare_all(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.op = OP_NEXT; bus.skip = 1'b0; bus.target = '0;
    model_reset();
    #12;
    compare_all("rst0");
    chk("rst0_pc_const", 32'(bus.counter), 32'h0);
    chk("rst0_empty_const", 32'(bus.empty), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // increment, skip and hold
    step("nx1", 1, OP_NEXT, 0, 0);
    step("nx2", 1, OP_NEXT, 0, 0);
    step("nx3", 1, OP_NEXT, 0, 0);
    chk("nx3_const", 32'(bus.counter), 32'h3);
    step("skp", 1, OP_NEXT, 1, 0);
    chk("skp_const", 32'(bus.counter), 32'h5);
    step("hold1", 0, OP_GOTO, 0, 32'h123);
    step("hold2", 0, OP_CALL, 0, 32'h456);
    chk("hold_const", 32'(bus.counter), 32'h5);

    // wrap at top of address space
    step("wg1", 1, OP_GOTO, 0, 32'h1FFF);
    step("wn1", 1, OP_NEXT, 0, 0);
    chk("wrap1_const", 32'(bus.counter), 32'h0);
    step("wg2", 1, OP_GOTO, 0, 32'h1FFF);
    step("wn2", 1, OP_NEXT, 1, 0);
    chk("wrap2_const", 32'(bus.counter), 32'h1);

    // nested call/return
    step("ng", 1, OP_GOTO, 0, 32'h10);
    step("nc1", 1, OP_CALL, 1, 32'h100);
    step("nc2", 1, OP_CALL, 0, 32'h200);
    chk("nest_sp_const", 32'(bus.sp), 32'h2);
    chk("nest_pc_const", 32'(bus.counter), 32'h200);
    step("nr1", 1, OP_RET, 1, 0);
    chk("nest_r1_const", 32'(bus.counter), 32'h101);
    step("nr2", 1, OP_RET, 0, 0);
    chk("nest_r2_const", 32'(bus.counter), 32'h11);
    chk("nest_empty_const", 32'(bus.empty), 32'h1);

    // overflow: nine calls into an eight-deep stack
    apply_reset();
    for (int i = 0; i < 9; i++) step("ovc", 1, OP_CALL, 0, int'(bus.counter) + 32'h10);
`ifndef PC_STACK_OVF_TRAP_EN
    chk("ovf_full_const", 32'(bus.full), 32'h1);
    chk("ovf_sp_const", 32'(bus.sp), 32'h8);
    for (int k = 0; k < 8; k++) begin
      step("ovr", 1, OP_RET, 0, 0);
      chk("ovf_ret_const", 32'(bus.counter), 32'h81 - 32'(k) * 32'h10);
    end
`else
    for (int k = 0; k < 9; k++) step("ovr", 1, OP_RET, 0, 0);
`endif
    step("unf", 1, OP_RET, 0, 0);

`ifdef PC_STACK_OVF_TRAP_EN
    // trapped underflow from reset
    apply_reset();
    step("tu", 1, OP_RET, 0, 0);
    chk("trap_pc_const", 32'(bus.counter), 32'h0);
    chk("trap_err_const", 32'(bus.stk_err), 32'h1);
    step("tg", 1, OP_GOTO, 0, 32'h40);
    chk("trap_goto_const", 32'(bus.counter), 32'h40);
    chk("trap_sticky_const", 32'(bus.stk_err), 32'h1);
`endif

    // async reset between edges while calls are in flight
    step("ac1", 1, OP_CALL, 0, 32'h300);
    step("ac2", 1, OP_CALL, 0, 32'h310);
    step("ac3", 1, OP_CALL, 0, 32'h320);
    bus.en = 1'b1; bus.op = OP_CALL; bus.target = 13'h330;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", 32'(bus.counter), 32'h0);
    chk("arst_sp", 32'(bus.sp), 32'h0);
    chk("arst_err", 32'(bus.stk_err), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all("arst_hold");
    @(negedge clk);
    reset = 1'b0;
    step("arst_first", 1, OP_CALL, 0, 32'h330);

    // randomized streams: call-heavy, ret-heavy, then mixed
    for (int i = 0; i < 360; i++) begin
      int r;
      pc_op_e o;
      int t;
      r = $urandom_range(0, 99);
      if (i < 120)      o = (r < 50) ? OP_CALL : (r < 65) ? OP_RET  : (r < 85) ? OP_NEXT : OP_GOTO;
      else if (i < 240) o = (r < 50) ? OP_RET  : (r < 65) ? OP_CALL : (r < 85) ? OP_NEXT : OP_GOTO;
      else              o = pc_op_e'(r % 4);
      t = ($urandom_range(0, 3) == 0) ? 32'h1FFF : int'($urandom_range(0, MOD - 1));
      step("rnd", $urandom_range(0, 4) != 0, o, 1'($urandom_range(0, 1)), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
